hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
Parametrised next-generation hazard unit for the 5-stage RISC-V pipeline. It keeps operand forwarding, load-use stalling and branch flushing, and adds three things:
- sequential tracking of a multi-cycle MUL/DIV unit in Execute, with a latency counter;
- data-memory wait-state stalling;
- x0-safe load-use detection.
It sits beside the pipeline registers and drives their stall/flush enables plus the E-stage forwarding muxes.

Parameters:
REG_AW, 5, register-address width
MD_LATENCY, 4, total Execute-stage cycles of a MUL/DIV op (legal 2..16)
CNT_W, 4, width of internal MD counter (must hold MD_LATENCY-1)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  synchronous active-low reset
Rs1D  in  REG_AW  source 1 in Decode
Rs2D  in  REG_AW  source 2 in Decode
Rs1E  in  REG_AW  source 1 in Execute
Rs2E  in  REG_AW  source 2 in Execute
RdE  in  REG_AW  destination in Execute
RdM  in  REG_AW  destination in Memory
RdW  in  REG_AW  destination in Writeback
PCSrcE  in  1  taken branch/jump resolved in Execute
ResultSrcE0  in  1  load in Execute
MdOpE  in  1  MUL/DIV instruction occupying Execute
RegWriteM  in  1  Memory-stage writes rd
RegWriteW  in  1  Writeback-stage writes rd
MemReadyM  in  1  data memory completes access this cycle (tie 1 if no wait states)
ForwardAE  out  2  00 regfile, 10 from M, 01 from W
ForwardBE  out  2  same encoding for operand B
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
FlushM  out  1  clear EX/MEM (bubble)
FlushW  out  1  clear MEM/WB (bubble)
MdBusy  out  1  MD FSM in BUSY

Behaviour:
- Forwarding, combinational:
  - Rs1E==0 -> ForwardAE=00.
  - Else M match with RegWriteM -> 10.
  - Else W match with RegWriteW -> 01.
  - Else 00.
  - Same rules for Rs2E/ForwardBE.
  - Forwarding is valid in every state.
- lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE). Effect: StallF=StallD=1, FlushE=1 for that cycle.
- MD FSM, two states: IDLE, BUSY.
  - IDLE: MdOpE=1 & !memStall -> BUSY, cnt<=MD_LATENCY-2, same cycle mdStall=1.
  - BUSY: mdStall=1. If cnt==0 & !memStall -> IDLE, mdStall=0 that cycle (op leaves E on next edge). Else cnt decrements when !memStall and holds under memStall.
  - mdStall combinational = (IDLE & MdOpE) | (BUSY & cnt!=0).
  - Net: the op occupies E exactly MD_LATENCY cycles absent mem stalls.
  - mdStall: StallF=StallD=StallE=1, FlushM=1.
- memStall = !MemReadyM: StallF=StallD=StallE=StallM=1, FlushW=1. Highest priority; suppresses FlushD, FlushE, FlushM from every other source.
- Branch: PCSrcE & !memStall & !mdStall -> FlushD=1, FlushE=1.
  - A branch with mdStall active is deferred. The branch cannot be in E alongside an MD op, but the rule still holds.
- lwStall is ignored while mdStall or memStall is active, because E is held.
- Priority, high to low: memStall, mdStall, branch flush, lwStall.
- All stall/flush outputs are combinational from inputs and FSM state.
- Reset (rst_n=0 at edge): state<=IDLE, cnt<=0.
  - While rst_n=0: every Stall*=0, FlushD=FlushE=FlushM=FlushW=1, MdBusy=0, Forward*=00.
  - Reset mid-BUSY aborts the op; the first cycle after reset is IDLE.
- MdBusy = (state==BUSY), registered-state decode.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds output ports StallCycles (32, out) and FlushCount (32, out).
  - StallCycles increments every cycle StallF=1.
  - FlushCount increments every cycle FlushD=1.
  - Both saturate at 0xFFFFFFFF and clear to 0 on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Forwarding: RdM=RdW=5, Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. Same with RegWriteM=0 -> 01. Rs1E=0 -> 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> one cycle StallF=StallD=FlushE=1. RdE=0, Rs1D=0 -> no stall.
- MD op: MdOpE=1 with MD_LATENCY=4 -> StallE=FlushM=1 for 3 cycles, MdBusy high cycles 2-4, released on cycle 4. Repeat with MD_LATENCY=2 -> one stall cycle.
- Mem wait: MemReadyM=0 for 3 cycles during BUSY -> StallM=FlushW=1 for those 3 cycles, cnt frozen, total MD occupancy 4+3.
- Branch: PCSrcE=1, no stalls -> FlushD=FlushE=1 one cycle. PCSrcE=1 with MemReadyM=0 -> flushes suppressed.
- Reset mid-BUSY: rst_n=0 one cycle at cnt=1 -> flushes asserted, MdBusy=0 next cycle. With HAZARD_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RISC-V pipeline: forwarding, load-use, branch flush,
// multi-cycle MUL/DIV tracking and memory wait states. Optional HAZARD_PERF_CNT_EN adds perf counters.
module hazard_unit_mc #(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              PCSrcE,
    input  logic              ResultSrcE0,
    input  logic              MdOpE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
`ifdef HAZARD_PERF_CNT_EN
    output logic              MdBusy,
    output logic [31:0]       StallCycles,
    output logic [31:0]       FlushCount
`else
    output logic              MdBusy
`endif
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             mem_stall, md_stall, lw_stall, branch, lw_eff;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdm,
        input logic [REG_AW-1:0] rdw,
        input logic              wm,
        input logic              ww
    );
        if (rs == '0)             return 2'b00;
        else if (wm && rs == rdm) return 2'b10;
        else if (ww && rs == rdw) return 2'b01;
        else                      return 2'b00;
    endfunction

    assign mem_stall = !MemReadyM;
    assign md_stall  = (state == IDLE && MdOpE) || (state == BUSY && cnt != '0);
    assign lw_stall  = ResultSrcE0 && (RdE != '0) && (Rs1D == RdE || Rs2D == RdE);
    assign branch    = PCSrcE && !mem_stall && !md_stall;
    // A load-use stall is pointless while E is held or the D instruction is being flushed.
    assign lw_eff    = lw_stall && !mem_stall && !md_stall && !branch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (MdOpE && !mem_stall) begin
                state_n = BUSY;
                cnt_n   = CNT_W'(MD_LATENCY - 2);
            end
            BUSY: if (!mem_stall) begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushM    = 1'b1;
        FlushW    = 1'b1;
        MdBusy    = 1'b0;
        if (rst_n) begin
            ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
            StallF    = mem_stall || md_stall || lw_eff;
            StallD    = mem_stall || md_stall || lw_eff;
            StallE    = mem_stall || md_stall;
            StallM    = mem_stall;
            FlushD    = branch;
            FlushE    = branch || lw_eff;
            FlushM    = !mem_stall && md_stall;
            FlushW    = mem_stall;
            MdBusy    = (state == BUSY);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (StallF && StallCycles != '1) StallCycles <= StallCycles + 32'd1;
            if (FlushD && FlushCount  != '1) FlushCount  <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: vector table for combinational hazards plus
// hand-written MUL/DIV, memory-wait and reset sequences on MD_LATENCY=4 and =2 instances.
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       PCSrcE, ResultSrcE0, RegWriteM, RegWriteW, MemReadyM;
    logic       md_a, md_b;

    logic [1:0] fa_a, fb_a, fa_b, fb_b;
    logic       sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fm_a, fw_a, bz_a;
    logic       sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fm_b, fw_b, bz_b;
    logic [8:0] ctl_a, ctl_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ctl_a = {sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fm_a, fw_a, bz_a};
    assign ctl_b = {sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fm_b, fw_b, bz_b};

    hazard_unit_mc #(.REG_AW(5), .MD_LATENCY(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0),
        .MdOpE(md_a), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadyM(MemReadyM),
        .ForwardAE(fa_a), .ForwardBE(fb_a), .StallF(sf_a), .StallD(sd_a), .StallE(se_a),
        .StallM(sm_a), .FlushD(fd_a), .FlushE(fe_a), .FlushM(fm_a), .FlushW(fw_a),
`ifdef HAZARD_PERF_CNT_EN
        .MdBusy(bz_a), .StallCycles(sc_a), .FlushCount(fc_a)
`else
        .MdBusy(bz_a)
`endif
    );

    hazard_unit_mc #(.REG_AW(5), .MD_LATENCY(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0),
        .MdOpE(md_b), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadyM(MemReadyM),
        .ForwardAE(fa_b), .ForwardBE(fb_b), .StallF(sf_b), .StallD(sd_b), .StallE(se_b),
        .StallM(sm_b), .FlushD(fd_b), .FlushE(fe_b), .FlushM(fm_b), .FlushW(fw_b),
`ifdef HAZARD_PERF_CNT_EN
        .MdBusy(bz_b), .StallCycles(sc_b), .FlushCount(fc_b)
`else
        .MdBusy(bz_b)
`endif
    );

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       pc, ld, wm, ww, rdy;
        logic [1:0] fa, fb;
        logic [8:0] ctl;   // {SF,SD,SE,SM,FD,FE,FM,FW,MdBusy}
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        PCSrcE = 0; ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; MemReadyM = 1;
        md_a = 0; md_b = 0;
    endtask

    // One cycle of the MD sequences: drive at negedge, check both instances before the next edge.
    task automatic cyc(input string nm, input logic ma, input logic mb, input logic rdy,
                       input logic [8:0] ea, input logic [8:0] eb);
        @(negedge clk);
        md_a = ma; md_b = mb; MemReadyM = rdy;
        #1;
        chk({nm, "_a"}, 32'(ctl_a), 32'(ea));
        chk({nm, "_b"}, 32'(ctl_b), 32'(eb));
    endtask

    initial begin
        tbl[0]  = '{0,0,5,0,0,5,5, 0,0,1,1,1, 2'b10,2'b00, 9'b0000_0000_0};
        tbl[1]  = '{0,0,5,0,0,5,5, 0,0,0,1,1, 2'b01,2'b00, 9'b0000_0000_0};
        tbl[2]  = '{0,0,0,5,0,5,5, 0,0,1,1,1, 2'b00,2'b10, 9'b0000_0000_0};
        tbl[3]  = '{0,0,5,6,0,5,6, 0,0,1,1,1, 2'b10,2'b01, 9'b0000_0000_0};
        tbl[4]  = '{0,7,0,0,7,0,0, 0,1,0,0,1, 2'b00,2'b00, 9'b1100_0100_0};
        tbl[5]  = '{0,3,0,0,0,0,0, 0,1,0,0,1, 2'b00,2'b00, 9'b0000_0000_0};
        tbl[6]  = '{7,0,0,0,7,0,0, 0,1,0,0,1, 2'b00,2'b00, 9'b1100_0100_0};
        tbl[7]  = '{7,0,0,0,7,0,0, 0,0,0,0,1, 2'b00,2'b00, 9'b0000_0000_0};
        tbl[8]  = '{0,0,0,0,0,0,0, 1,0,0,0,1, 2'b00,2'b00, 9'b0000_1100_0};
        tbl[9]  = '{0,0,0,0,0,0,0, 1,0,0,0,0, 2'b00,2'b00, 9'b1111_0001_0};
        tbl[10] = '{0,7,0,0,7,0,0, 0,1,0,0,0, 2'b00,2'b00, 9'b1111_0001_0};
        tbl[11] = '{0,0,5,0,0,5,0, 0,0,1,0,0, 2'b10,2'b00, 9'b1111_0001_0};
        tbl[12] = '{0,0,5,5,0,5,5, 0,0,0,0,1, 2'b00,2'b00, 9'b0000_0000_0};

        // Reset with hazards on the inputs: outputs must be forced to the reset pattern.
        idle_inputs();
        rst_n = 0; Rs1E = 5; RdM = 5; RegWriteM = 1; PCSrcE = 1; MemReadyM = 0; md_a = 1;
        #1;
        chk("rst_ctl", 32'(ctl_a), 32'(9'b0000_1111_0));
        chk("rst_fwd", 32'(fa_a), 32'(2'b00));
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e;
            RdE = tbl[i].rde; RdM = tbl[i].rdm; RdW = tbl[i].rdw; PCSrcE = tbl[i].pc;
            ResultSrcE0 = tbl[i].ld; RegWriteM = tbl[i].wm; RegWriteW = tbl[i].ww;
            MemReadyM = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_fa", i), 32'(fa_a), 32'(tbl[i].fa));
            chk($sformatf("vec%0d_fb", i), 32'(fb_a), 32'(tbl[i].fb));
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_a), 32'(tbl[i].ctl));
        end
        @(negedge clk);
        idle_inputs();
`ifdef HAZARD_PERF_CNT_EN
        #1;
        chk("perf_stall", sc_a, 32'd5);
        chk("perf_flush", fc_a, 32'd1);
`endif

        // MD op, latency 4: three stall cycles, busy on cycles 2..4, released on cycle 4.
        cyc("md4_c1", 1, 0, 1, 9'b1110_0010_0, 9'b0);
        cyc("md4_c2", 1, 0, 1, 9'b1110_0010_1, 9'b0);
        cyc("md4_c3", 1, 0, 1, 9'b1110_0010_1, 9'b0);
        cyc("md4_c4", 1, 0, 1, 9'b0000_0000_1, 9'b0);
        cyc("md4_c5", 0, 0, 1, 9'b0000_0000_0, 9'b0);

        // MD op, latency 2: a single stall cycle.
        cyc("md2_c1", 0, 1, 1, 9'b0, 9'b1110_0010_0);
        cyc("md2_c2", 0, 1, 1, 9'b0, 9'b0000_0000_1);
        cyc("md2_c3", 0, 0, 1, 9'b0, 9'b0000_0000_0);

        // Memory wait for 3 cycles while BUSY: counter frozen, occupancy 4+3.
        cyc("mw_c1", 1, 0, 1, 9'b1110_0010_0, 9'b0);
        cyc("mw_c2", 1, 0, 0, 9'b1111_0001_1, 9'b1111_0001_0);
        cyc("mw_c3", 1, 0, 0, 9'b1111_0001_1, 9'b1111_0001_0);
        cyc("mw_c4", 1, 0, 0, 9'b1111_0001_1, 9'b1111_0001_0);
        cyc("mw_c5", 1, 0, 1, 9'b1110_0010_1, 9'b0);
        cyc("mw_c6", 1, 0, 1, 9'b1110_0010_1, 9'b0);
        cyc("mw_c7", 1, 0, 1, 9'b0000_0000_1, 9'b0);
        cyc("mw_c8", 0, 0, 1, 9'b0000_0000_0, 9'b0);

        // Reset while BUSY with cnt=1: op aborted, IDLE on the first cycle after reset.
        cyc("rb_c1", 1, 0, 1, 9'b1110_0010_0, 9'b0);
        cyc("rb_c2", 1, 0, 1, 9'b1110_0010_1, 9'b0);
        @(negedge clk);
        rst_n = 0; Rs1E = 5; RdM = 5; RegWriteM = 1;
        #1;
        chk("rb_rst_ctl", 32'(ctl_a), 32'(9'b0000_1111_0));
        chk("rb_rst_fwd", 32'(fa_a), 32'(2'b00));
        @(negedge clk);
        rst_n = 1; md_a = 0; Rs1E = 0; RdM = 0; RegWriteM = 0;
        #1;
        chk("rb_after_ctl", 32'(ctl_a), 32'(9'b0));
`ifdef HAZARD_PERF_CNT_EN
        chk("rb_perf_stall", sc_a, 32'd0);
        chk("rb_perf_flush", fc_a, 32'd0);
`endif
        // A new op after the abort must again take the full latency.
        cyc("rb_c4", 1, 0, 1, 9'b1110_0010_0, 9'b0);
        cyc("rb_c5", 1, 0, 1, 9'b1110_0010_1, 9'b0);
        cyc("rb_c6", 1, 0, 1, 9'b1110_0010_1, 9'b0);
        cyc("rb_c7", 1, 0, 1, 9'b0000_0000_1, 9'b0);
        cyc("rb_c8", 0, 0, 1, 9'b0, 9'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
